buffer_drain: RTL



---
 rtl/buffer_drain_pkg.sv | 11 +
 rtl/buffer_drain_acc.sv | 22 ++
 rtl/buffer_drain.sv | 68 ++++++
 3 files changed

// File: rtl/buffer_drain_pkg.sv
// buffer_drain_pkg: shared width default, FSM state encoding and counter-width helper for buffer_drain.
package buffer_drain_pkg;
  localparam int N_DEF = 32;
  typedef enum logic [1:0] {FILL = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/buffer_drain_acc.sv
// drain_acc: N-bit accumulate step with carry-based overflow; DRAIN_SATURATE_EN clamps the sum at all-ones.
module drain_acc
  import buffer_drain_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] din,
  input  logic         ovf,
  output logic [N-1:0] sum,
  output logic         ovf_nx
);
  logic [N:0] s;
  assign s = {1'b0, acc} + {1'b0, din};
`ifdef DRAIN_SATURATE_EN
  // an all-ones sum absorbs any later non-zero word through the carry, so it stays saturated
  assign sum = s[N] ? {N{1'b1}} : s[N-1:0];
`else
  assign sum = s[N-1:0];
`endif
  assign ovf_nx = ovf | s[N];
endmodule

// File: rtl/buffer_drain.sv
// buffer_drain: pops BURST words from the buffer FIFO (1-cycle read latency) and offers their sum on a valid/ready port.
// Build option DRAIN_SATURATE_EN makes the sum saturate instead of wrapping.
module buffer_drain
  import buffer_drain_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_empty,
  output logic         rd_en,
  input  logic [N-1:0] rd_data,
  output logic         acc_valid,
  input  logic         acc_ready,
  output logic [N-1:0] acc_data,
  output logic         acc_ovf
);
  localparam int CW = clog2(BURST + 1);
  localparam logic [CW-1:0] FULL = CW'(BURST);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);
  state_t        state;
  logic [CW-1:0] issued, received;
  logic          pend, ovf, ovf_nx;
  logic [N-1:0]  acc, sum;
  assign rd_en    = !rst && state == FILL && !rd_empty && issued < FULL;
  assign acc_data = acc;
  assign acc_ovf  = ovf;
  drain_acc #(.N(N)) u_acc (
    .acc   (acc),
    .din   (rd_data),
    .ovf   (ovf),
    .sum   (sum),
    .ovf_nx(ovf_nx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      issued    <= '0;
      received  <= '0;
      pend      <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      pend <= rd_en;
      if (rd_en) issued <= issued + CW'(1);
      if (pend) begin
        acc      <= sum;
        ovf      <= ovf_nx;
        received <= received + CW'(1);
      end
      if (state == FILL && rd_en && issued == LAST) state <= WAIT;
      if (state == WAIT && pend && received == LAST) begin
        state     <= HOLD;
        acc_valid <= 1'b1;
      end
      if (state == HOLD && acc_ready) begin
        state     <= FILL;
        acc_valid <= 1'b0;
        acc       <= '0;
        ovf       <= 1'b0;
        issued    <= '0;
        received  <= '0;
      end
    end
  end
endmodule
